// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM state encoding for the uart echo FIFO
// Optional build macro: UART_ECHO_CRLF_EN (adds the line-feed insertion states)
package uart_pkg;

    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] ASCII_CR = 8'h0D;
    localparam logic [DATA_W-1:0] ASCII_LF = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT_ACK,
        ST_WAIT_DONE
`ifdef UART_ECHO_CRLF_EN
        ,
        ST_LF_START,
        ST_LF_ACK,
        ST_LF_DONE
`endif
    } state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock byte FIFO with registered occupancy count
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   push, wdata  write request and byte; ignored when full unless pop is also high
//   pop          remove the head entry (never issued while empty)
//   rdata        current head entry (combinational read)
//   count        occupancy after the most recent edge, 0..DEPTH
//   full, empty  decoded from count
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_echo_fifo.sv
// rtl/uart_echo_fifo.sv - buffers received uart bytes and echoes them to the transmitter
// Optional build macro: UART_ECHO_CRLF_EN (send 0x0A after every echoed 0x0D)
// Ports:
//   CLK_i, RSTn_i            clock and asynchronous active-low reset
//   RX_VALID_i, RX_BYTE_i    one-cycle receive pulse and its byte
//   TX_BUSY_i                transmitter busy flag
//   TX_START_o, TX_BYTE_o    one-cycle transmit strobe and the byte to send
//   LED_o                    last received byte (including dropped ones)
//   COUNT_o                  FIFO occupancy
//   OVERFLOW_o               sticky flag: a received byte was dropped
module uart_echo_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              CLK_i,
    input  logic              RSTn_i,
    input  logic              RX_VALID_i,
    input  logic [DATA_W-1:0] RX_BYTE_i,
    input  logic              TX_BUSY_i,
    output logic              TX_START_o,
    output logic [DATA_W-1:0] TX_BYTE_o,
    output logic [DATA_W-1:0] LED_o,
    output logic [ADDR_W:0]   COUNT_o,
    output logic              OVERFLOW_o
);

    state_t            state;
    logic              pop;
    logic [DATA_W-1:0] head;
    logic              full;
    logic              empty;

    // The head is consumed in the LOAD cycle, the same edge that captures it into TX_BYTE_o.
    assign pop = (state == ST_LOAD);

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk   (CLK_i),
        .rst_n (RSTn_i),
        .push  (RX_VALID_i),
        .wdata (RX_BYTE_i),
        .pop   (pop),
        .rdata (head),
        .count (COUNT_o),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge CLK_i or negedge RSTn_i) begin
        if (!RSTn_i) begin
            LED_o      <= '0;
            OVERFLOW_o <= 1'b0;
        end else if (RX_VALID_i) begin
            LED_o <= RX_BYTE_i;
            if (full && !pop) OVERFLOW_o <= 1'b1;
        end
    end

    always_ff @(posedge CLK_i or negedge RSTn_i) begin
        if (!RSTn_i) begin
            state      <= ST_IDLE;
            TX_START_o <= 1'b0;
            TX_BYTE_o  <= '0;
        end else begin
            TX_START_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A busy transmitter here belongs to someone else; wait it out.
                    if (!empty && !TX_BUSY_i) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    TX_BYTE_o  <= head;
                    TX_START_o <= 1'b1;
                    state      <= ST_START;
                end
                ST_START: begin
                    state <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (TX_BUSY_i) state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (!TX_BUSY_i) begin
`ifdef UART_ECHO_CRLF_EN
                        if (TX_BYTE_o == ASCII_CR) begin
                            TX_BYTE_o  <= ASCII_LF;
                            TX_START_o <= 1'b1;
                            state      <= ST_LF_START;
                        end else begin
                            state <= ST_IDLE;
                        end
`else
                        state <= ST_IDLE;
`endif
                    end
                end
`ifdef UART_ECHO_CRLF_EN
                ST_LF_START: begin
                    state <= ST_LF_ACK;
                end
                ST_LF_ACK: begin
                    if (TX_BUSY_i) state <= ST_LF_DONE;
                end
                ST_LF_DONE: begin
                    if (!TX_BUSY_i) state <= ST_IDLE;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_echo_fifo.md
Name: uart_echo_fifo

Overview:
Sits between the UART receiver and transmitter on the iCE40 design. It consumes the received pulse and byte from the uart core and buffers bytes in a small synchronous FIFO. It then drives the uart transmit strobe and byte one byte at a time, giving a loopback echo. It also latches the last received byte for the LED bank and reports FIFO fill and overflow.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
ADDR_W, 4, log2(DEPTH); count width is ADDR_W+1

Ports:
CLK_i  input  1  master clock, same clock as the uart core
RSTn_i  input  1  asynchronous active-low reset
RX_VALID_i  input  1  one-cycle pulse from the uart receiver: byte received
RX_BYTE_i  input  8  received byte; valid when RX_VALID_i=1
TX_BUSY_i  input  1  uart "is transmitting" flag
TX_START_o  output  1  one-cycle transmit strobe to the uart
TX_BYTE_o  output  8  byte to transmit; stable from the TX_START_o cycle until back in IDLE
LED_o  output  8  last byte accepted on RX_VALID_i
COUNT_o  output  ADDR_W+1  current FIFO occupancy, 0..DEPTH
OVERFLOW_o  output  1  sticky: a received byte was dropped

Behaviour:
- Reset (RSTn_i low, asynchronous): FIFO empty, COUNT_o=0, OVERFLOW_o=0, TX_START_o=0, TX_BYTE_o=0x00, LED_o=0x00, FSM=IDLE. A reset mid-transmission abandons the byte; the uart is not signalled.
- LED_o updates on every RX_VALID_i, even when the byte is dropped.
- Push: on RX_VALID_i, if not full or a pop occurs in the same cycle, write RX_BYTE_i at wr_ptr and increment wr_ptr (mod DEPTH).
- Full with no pop: drop the byte and set OVERFLOW_o; it stays set until reset.
- Simultaneous push and pop: both take effect, COUNT_o unchanged. Pop from empty never occurs.
- COUNT_o is registered and reflects the state after the current edge. Pointers wrap naturally at DEPTH.
- FSM states: IDLE, LOAD, START, WAIT_ACK, WAIT_DONE.
- IDLE: if COUNT_o>0 and TX_BUSY_i=0, go to LOAD.
- LOAD: pop the head into TX_BYTE_o register, go to START.
- START: TX_START_o=1 for exactly this cycle, go to WAIT_ACK.
- WAIT_ACK: wait for TX_BUSY_i=1, then go to WAIT_DONE.
- WAIT_DONE: wait for TX_BUSY_i=0, then go to IDLE.
- Latency: a byte pushed into an empty FIFO while the uart is idle gives TX_START_o 3 cycles after the RX_VALID_i edge (IDLE, LOAD, START).
- Back-to-back bytes: at least one IDLE cycle between WAIT_DONE exit and the next LOAD.
- TX_BUSY_i high while in IDLE (external transmitter use): hold in IDLE.

Optional Feature:
UART_ECHO_CRLF_EN
- Defined: after transmitting a byte equal to 0x0D, the FSM goes through extra states LF_START then LF_ACK/LF_DONE and transmits 0x0A, without consuming a FIFO entry, before returning to IDLE. The same busy handshake applies.
- Undefined: pure byte echo; no 0x0A insertion and no extra states are synthesised.

Decomposition:
- Package uart_pkg holds:
  - DATA_W=8
  - ASCII_CR=8'h0D and ASCII_LF=8'h0A
  - the FSM state localparams/enum
- Sub-module uart_sync_fifo (parameters DEPTH, ADDR_W) holds the storage, pointers, count, full/empty and the push/pop rules.
- uart_echo_fifo holds the FSM, LED latch and overflow flag.

Test Plan:
- Reset, then a single 0x41 pulse with TX_BUSY_i modelled as 1 for 10 cycles after the start -> TX_START_o 3 cycles later with TX_BYTE_o=0x41, one pulse only, LED_o=0x41, COUNT_o returns to 0.
- Burst of 5 bytes 0x30..0x34 on consecutive cycles with a slow uart model -> five TX_START_o pulses in order 0x30..0x34, each only after TX_BUSY_i falls; COUNT_o peaks at 4 or 5.
- Push 17 bytes while TX_BUSY_i is held high -> COUNT_o=16, OVERFLOW_o=1, the 17th byte is dropped, LED_o equals the 17th byte. Release busy -> first 16 bytes are echoed.
- Push exactly when full in the same cycle as a LOAD pop -> byte accepted, OVERFLOW_o stays 0, COUNT_o unchanged.
- Assert RSTn_i low during WAIT_DONE -> all outputs 0 immediately; after release no stale TX_START_o appears.
- With UART_ECHO_CRLF_EN, push 0x0D -> TX_START_o with 0x0D, then a second TX_START_o with 0x0A; COUNT_o decrements by only 1.
